// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit positions and multiplier FSM states shared by the alu_seq slice.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one bit of B per cycle; holds the product in DONE until acked.
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int BW_DATA = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               ack_i,
    input  logic [BW_DATA-1:0] a_i,
    input  logic [BW_DATA-1:0] b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BW_DATA-1:0] p_o
);

    localparam int BW_CNT = $clog2(BW_DATA);

    mul_state_e         state_q, state_d;
    logic [BW_DATA-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic [BW_CNT-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                acc_d   = '0;
                a_d     = a_i;
                b_d     = b_i;
                cnt_d   = '0;
            end
            RUN: begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + BW_CNT'(1);
                if (cnt_q == BW_CNT'(BW_DATA - 1)) state_d = DONE;
            end
            DONE: if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign p_o    = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flags and valid/ready handshake on both sides.
// Define ALU_SEQ_MUL_EN to add the iterative MUL op (1101); otherwise 1101 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_TAG  = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:0]         i_op,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic [BW_TAG-1:0]  i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_y,
    output logic [3:0]         o_flags,
    output logic               o_illegal,
    output logic [BW_TAG-1:0]  o_tag
);

    localparam int BW_SHAMT = $clog2(BW_DATA);
    localparam int MSB      = BW_DATA - 1;

    logic               rdy_q, val_q, val_d, ill_q, ill_d;
    logic [BW_DATA-1:0] y_q, y_d;
    logic [3:0]         flags_q, flags_d, flags_nxt;
    logic [BW_TAG-1:0]  tag_q, tag_d, mul_tag;
    logic               busy, mul_done, mul_ok, out_free, acc, is_mul, ld_alu, ld_mul, ld;
    logic               binv, c, v, arith, ill_alu;
    logic [BW_DATA-1:0] mul_p, bx, y_alu, y_nxt;
    logic [BW_DATA:0]   sum;
    logic [BW_SHAMT-1:0] sh;

    assign out_free = ~val_q | i_ready;
    assign o_ready  = rdy_q & ~busy & out_free;
    assign acc      = i_valid & o_ready;
    assign is_mul   = i_op == OP_MUL;

`ifdef ALU_SEQ_MUL_EN
    logic [BW_TAG-1:0] mtag_q;

    alu_mul_seq #(.BW_DATA(BW_DATA)) u_mul (
        .clk_i   (i_clk),
        .rstn_i  (i_rstn),
        .start_i (acc & is_mul),
        .ack_i   (out_free),
        .a_i     (i_a),
        .b_i     (i_b),
        .busy_o  (busy),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );

    always_ff @(posedge i_clk) mtag_q <= !i_rstn ? '0 : (acc & is_mul) ? i_tag : mtag_q;

    assign mul_tag = mtag_q;
    assign mul_ok  = 1'b1;
`else
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_p    = '0;
    assign mul_tag  = '0;
    assign mul_ok   = 1'b0;
`endif

    // SLT has op[2]=0 but still needs A-B from the shared adder.
    assign binv    = i_op[2] | (i_op == OP_SLT);
    assign bx      = binv ? ~i_b : i_b;
    assign sum     = {1'b0, i_a} + {1'b0, bx} + {{BW_DATA{1'b0}}, binv};
    assign c       = sum[BW_DATA];
    assign v       = (i_a[MSB] == bx[MSB]) & (sum[MSB] != i_a[MSB]);
    assign sh      = i_b[BW_SHAMT-1:0];
    assign arith   = ~i_op[3] & i_op[1];
    assign ill_alu = (i_op[3:1] == 3'b111) | (is_mul & ~mul_ok);

    always_comb begin
        case (i_op)
            OP_AND, OP_ANDN: y_alu = i_a & bx;
            OP_OR, OP_ORN:   y_alu = i_a | bx;
            OP_ADD, OP_SUB:  y_alu = sum[MSB:0];
            OP_SLT:          y_alu = {{MSB{1'b0}}, sum[MSB] ^ v};
            OP_SLTU:         y_alu = {{MSB{1'b0}}, ~c};
            OP_XOR:          y_alu = i_a ^ i_b;
            OP_NOR:          y_alu = ~(i_a | i_b);
            OP_SLL:          y_alu = i_a << sh;
            OP_SRL:          y_alu = i_a >> sh;
            OP_SRA:          y_alu = $signed(i_a) >>> sh;
            default:         y_alu = '0;
        endcase
    end

    assign ld_mul = mul_done & out_free;
    assign ld_alu = acc & ~(is_mul & mul_ok);
    assign ld     = ld_mul | ld_alu;
    assign y_nxt  = ld_mul ? mul_p : y_alu;

    always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_N] = y_nxt[MSB];
        flags_nxt[FLAG_Z] = y_nxt == '0;
        flags_nxt[FLAG_C] = ~ld_mul & arith & c;
        flags_nxt[FLAG_V] = ~ld_mul & arith & (i_op != OP_SLTU) & v;
    end

    assign val_d   = ld | (val_q & ~i_ready);
    assign y_d     = ld ? y_nxt : y_q;
    assign flags_d = ld ? flags_nxt : flags_q;
    assign ill_d   = ld ? ~ld_mul & ill_alu : ill_q;
    assign tag_d   = ld ? (ld_mul ? mul_tag : i_tag) : tag_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rdy_q   <= 1'b0;
            val_q   <= 1'b0;
            y_q     <= '0;
            flags_q <= '0;
            ill_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            rdy_q   <= 1'b1;
            val_q   <= val_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            ill_q   <= ill_d;
            tag_q   <= tag_d;
        end
    end

    assign o_valid   = val_q;
    assign o_y       = y_q;
    assign o_flags   = flags_q;
    assign o_illegal = ill_q;
    assign o_tag     = tag_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (BW_DATA=32).
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rstn, i_valid, i_ready, o_ready, o_valid, o_illegal;
    logic [3:0]  i_op, o_flags, i_tag, o_tag;
    logic [31:0] i_a, i_b, o_y;
    int          n_vec = 0, n_bad = 0;

    alu_seq #(.BW_DATA(32), .BW_TAG(4)) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_y       (o_y),
        .o_flags   (o_flags),
        .o_illegal (o_illegal),
        .o_tag     (o_tag)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] ey, input logic [3:0] ef, input logic ei);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = tag;
        tick();
        i_valid = 1'b0;
        chk({nm, ".vld"}, o_valid, 1);
        chk({nm, ".y"}, o_y, ey);
        chk({nm, ".flags"}, o_flags, ef);
        chk({nm, ".ill"}, o_illegal, ei);
        chk({nm, ".tag"}, o_tag, tag);
    endtask

    initial begin
        i_rstn = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
        i_op = OP_ADD; i_a = 32'd1; i_b = 32'd1; i_tag = 4'h3;
        repeat (3) tick();
        chk("rst.vld", o_valid, 0);
        chk("rst.rdy", o_ready, 0);
        chk("rst.y", o_y, 0);
        chk("rst.flags", o_flags, 0);
        chk("rst.ill", o_illegal, 0);
        chk("rst.tag", o_tag, 0);
        i_rstn = 1'b1; i_valid = 1'b0;
        tick();
        chk("rel.rdy", o_ready, 1);
        chk("rel.vld", o_valid, 0);

        i_ready = 1'b1;
        run("add_ovf", OP_ADD,  32'h7FFFFFFF, 32'h1,        4'h1, 32'h80000000, 4'b1001, 0);
        run("sub_eq",  OP_SUB,  32'd5,        32'd5,        4'h2, 32'h0,        4'b0110, 0);
        run("slt",     OP_SLT,  32'h80000000, 32'h1,        4'h3, 32'h1,        4'b0011, 0);
        run("sltu",    OP_SLTU, 32'h80000000, 32'h1,        4'h4, 32'h0,        4'b0110, 0);
        run("sra4",    OP_SRA,  32'hF0000000, 32'd4,        4'h5, 32'hFF000000, 4'b1000, 0);
        run("sll_wrap",OP_SLL,  32'h3,        32'h21,       4'h6, 32'h6,        4'b0000, 0);
        run("and",     OP_AND,  32'hF0F0,     32'hFF00,     4'h7, 32'hF000,     4'b0000, 0);
        run("andn",    OP_ANDN, 32'hFFFF,     32'h00FF,     4'h8, 32'hFF00,     4'b0000, 0);
        run("nor",     OP_NOR,  32'h0,        32'h0,        4'h9, 32'hFFFFFFFF, 4'b1000, 0);
        run("xor",     OP_XOR,  32'hAAAA,     32'hAAAA,     4'hB, 32'h0,        4'b0100, 0);
        run("srl31",   OP_SRL,  32'h80000000, 32'd31,       4'hC, 32'h1,        4'b0000, 0);
        run("sra0",    OP_SRA,  32'h12345678, 32'hFFFFFFE0, 4'hD, 32'h12345678, 4'b0000, 0);
        run("ill",     4'b1111, 32'h1234,     32'h5678,     4'hA, 32'h0,        4'b0100, 1);
`ifndef ALU_SEQ_MUL_EN
        run("mul_ill", OP_MUL,  32'h3,        32'h3,        4'hE, 32'h0,        4'b0100, 1);
`endif
        tick();
        chk("drain.vld", o_valid, 0);

        i_ready = 1'b0;
        i_valid = 1'b1; i_op = OP_ADD; i_a = 32'd1; i_b = 32'd1; i_tag = 4'h1;
        tick();
        chk("bp.rdy0", o_ready, 0);
        i_a = 32'd2; i_b = 32'd2; i_tag = 4'h2;
        repeat (2) begin
            tick();
            chk("bp.hold.vld", o_valid, 1);
            chk("bp.hold.y", o_y, 32'd2);
            chk("bp.hold.tag", o_tag, 4'h1);
            chk("bp.hold.rdy", o_ready, 0);
        end
        i_ready = 1'b1;
        #1;
        chk("bp.rdy1", o_ready, 1);
        tick();
        chk("bp.y2", o_y, 32'd4);
        chk("bp.tag2", o_tag, 4'h2);
        i_a = 32'd3; i_b = 32'd3; i_tag = 4'h3;
        tick();
        chk("bp.y3", o_y, 32'd6);
        chk("bp.tag3", o_tag, 4'h3);
        chk("bp.vld3", o_valid, 1);
        i_valid = 1'b0;
        tick();
        chk("bp.drain", o_valid, 0);

`ifdef ALU_SEQ_MUL_EN
        begin
            int  k;
            bit  rdy_seen, vld_seen;
            i_valid = 1'b1; i_op = OP_MUL; i_a = 32'hFFFFFFFF; i_b = 32'd3; i_tag = 4'h5;
            tick();
            i_valid = 1'b0;
            k = 0; rdy_seen = 0;
            while (!o_valid && k < 100) begin
                if (o_ready) rdy_seen = 1;
                tick();
                k++;
            end
            chk("mul.lat", k, 33);
            chk("mul.rdy_low", rdy_seen, 0);
            chk("mul.y", o_y, 32'hFFFFFFFD);
            chk("mul.flags", o_flags, 4'b1000);
            chk("mul.tag", o_tag, 4'h5);
            chk("mul.ill", o_illegal, 0);
            i_valid = 1'b1; i_tag = 4'h6;
            tick();
            i_valid = 1'b0;
            repeat (9) tick();
            i_rstn = 1'b0;
            tick();
            i_rstn = 1'b1;
            vld_seen = 0;
            repeat (50) begin
                tick();
                if (o_valid) vld_seen = 1;
            end
            chk("mul.rst.novld", vld_seen, 0);
            chk("mul.rst.rdy", o_ready, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
